// File: rtl/ham_pkg.sv
// rtl/ham_pkg.sv - shared Hamming SECDED types, defaults and layout helpers
//
// Contents:
//   DEF_DATA_BITS, DEF_CNT_W : default parameter values.
//   ham_status_e             : decode status (NONE/CORRECTED/DOUBLE/MULTI).
//   is_check_pos(pos)        : 1 when a 1-based position holds a check bit.
//   data_index(pos)          : data bit index stored at a 1-based data position.
//                              Also used by the encoder.
package ham_pkg;

  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_CNT_W     = 16;

  typedef enum logic [1:0] {
    ST_NONE      = 2'b00,
    ST_CORRECTED = 2'b01,
    ST_DOUBLE    = 2'b10,
    ST_MULTI     = 2'b11
  } ham_status_e;

  // Check bits occupy the power-of-two positions.
  function automatic bit is_check_pos(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Every check position below pos shifts the data index down by one.
  function automatic int data_index(input int pos);
    int n_chk;
    n_chk = 0;
    for (int k = 1; k <= pos; k = k * 2) n_chk++;
    return pos - n_chk - 1;
  endfunction

endpackage

// File: rtl/ham_dec_pipe_if.sv
// rtl/ham_dec_pipe_if.sv - one decoder lane's stream and counter signals
//
// Signals:
//   in_data/in_valid/in_ready        : received word, upstream side.
//   out_data/out_status/out_err_pos  : decode result, downstream side.
//   out_valid/out_ready              : downstream handshake.
//   corr_cnt/uncorr_cnt              : saturating error counters.
// Modports:
//   master : the lane's user (drives in_*, out_ready).
//   slave  : the decoder lane.
interface ham_dec_pipe_if
  import ham_pkg::*;
#(
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int ENCODED_WORD = DEF_DATA_BITS + $clog2(DEF_DATA_BITS) + 1,
  parameter int CNT_W        = DEF_CNT_W
);
  localparam int POS_W = $clog2(ENCODED_WORD + 2);

  logic [ENCODED_WORD+1:1] in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_BITS-1:0]    out_data;
  logic [1:0]              out_status;
  logic [POS_W-1:0]        out_err_pos;
  logic                    out_valid;
  logic                    out_ready;
  logic [CNT_W-1:0]        corr_cnt;
  logic [CNT_W-1:0]        uncorr_cnt;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_status, out_err_pos, out_valid,
           corr_cnt, uncorr_cnt
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_status, out_err_pos, out_valid,
           corr_cnt, uncorr_cnt
  );

endinterface

// File: rtl/ham_dec_lane.sv
// rtl/ham_dec_lane.sv - single-lane 2-stage SECDED decoder with error counters
//
// Ports:
//   i_clk     : clock, rising edge.
//   i_rst     : asynchronous active-high reset.
//   i_clr_cnt : synchronous counter clear, wins over an increment.
//   bus       : lane stream and counters (ham_dec_pipe_if.slave).
module ham_dec_lane
  import ham_pkg::*;
#(
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int PARITY_BITS  = $clog2(DEF_DATA_BITS) + 1,
  parameter int ENCODED_WORD = DATA_BITS + PARITY_BITS,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_clr_cnt,
  ham_dec_pipe_if.slave   bus
);
  localparam int POS_W = $clog2(ENCODED_WORD + 2);
  localparam logic [PARITY_BITS-1:0] SYN_MAX = PARITY_BITS'(ENCODED_WORD);
  localparam logic [ENCODED_WORD:0]  BIT0    = {{ENCODED_WORD{1'b0}}, 1'b1};

  // Words are kept zero-based internally: bit i holds position i+1.
  logic [ENCODED_WORD:0]   w_in_word;
  logic [PARITY_BITS-1:0]  w_syn;
  logic                    w_par;
  logic                    w_advance;
  logic                    w_out_hs;
  logic [ENCODED_WORD:0]   w_fix_word;
  logic [DATA_BITS-1:0]    w_data;
  ham_status_e             w_status;
  logic [POS_W-1:0]        w_pos;

  logic                    r_s1_valid;
  logic [ENCODED_WORD:0]   r_s1_word;
  logic [PARITY_BITS-1:0]  r_s1_syn;
  logic                    r_s1_par;
  logic                    r_s2_valid;
  logic [DATA_BITS-1:0]    r_data;
  logic [1:0]              r_status;
  logic [POS_W-1:0]        r_pos;
  logic [CNT_W-1:0]        r_corr_cnt;
  logic [CNT_W-1:0]        r_uncorr_cnt;

  assign w_in_word = bus.in_data;
  // The whole lane moves together: both stages shift whenever stage 2 can drain.
  assign w_advance = !r_s2_valid || bus.out_ready;
  assign w_out_hs  = r_s2_valid && bus.out_ready;

  always_comb begin : syndrome
    logic [ENCODED_WORD:0] w_sh;
    w_syn = '0;
    w_sh  = '0;
    for (int p = 1; p <= ENCODED_WORD; p++) begin
      w_sh = w_in_word >> (p - 1);
      if (w_sh[0]) w_syn = w_syn ^ PARITY_BITS'(p);
    end
    w_par = ^w_in_word;
  end

  always_comb begin : classify
    logic [ENCODED_WORD:0] w_sh;
    w_fix_word = r_s1_word;
    w_status   = ST_NONE;
    w_pos      = '0;
    w_data     = '0;
    w_sh       = '0;
    if (r_s1_syn == '0) begin
      // Zero syndrome with odd parity: only the overall parity bit flipped.
      if (r_s1_par) begin
        w_status = ST_CORRECTED;
        w_pos    = POS_W'(ENCODED_WORD + 1);
      end
    end else if (!r_s1_par) begin
      w_status = ST_DOUBLE;
    end else if (r_s1_syn <= SYN_MAX) begin
      w_status   = ST_CORRECTED;
      w_pos      = POS_W'(r_s1_syn);
      w_fix_word = r_s1_word ^ (BIT0 << (r_s1_syn - 1'b1));
    end else begin
      // Syndrome points past the word: at least three bits flipped.
      w_status = ST_MULTI;
    end
    for (int p = 1; p <= ENCODED_WORD; p++) begin
      if (!is_check_pos(p)) begin
        w_sh   = w_fix_word >> (p - 1);
        w_data = w_data | (DATA_BITS'(w_sh[0]) << data_index(p));
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_word  <= '0;
      r_s1_syn   <= '0;
      r_s1_par   <= 1'b0;
      r_s2_valid <= 1'b0;
      r_data     <= '0;
      r_status   <= '0;
      r_pos      <= '0;
    end else if (w_advance) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_word <= w_in_word;
        r_s1_syn  <= w_syn;
        r_s1_par  <= w_par;
      end
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_data   <= w_data;
        r_status <= w_status;
        r_pos    <= w_pos;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else if (i_clr_cnt) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else if (w_out_hs) begin
      if (r_status == ST_CORRECTED && r_corr_cnt != '1)
        r_corr_cnt <= r_corr_cnt + 1'b1;
      if ((r_status == ST_DOUBLE || r_status == ST_MULTI) && r_uncorr_cnt != '1)
        r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
    end
  end

  assign bus.in_ready    = w_advance;
  assign bus.out_valid   = r_s2_valid;
  assign bus.out_data    = r_data;
  assign bus.out_status  = r_status;
  assign bus.out_err_pos = r_pos;
  assign bus.corr_cnt    = r_corr_cnt;
  assign bus.uncorr_cnt  = r_uncorr_cnt;

endmodule

// File: rtl/ham_dec_pipe.sv
// rtl/ham_dec_pipe.sv - dual independent pipelined SECDED decoder lanes
//
// Ports (x = a or b, lanes fully independent):
//   i_clk, i_rst               : clock, asynchronous active-high reset.
//   i_data_x, i_valid_x        : received word and valid.
//   o_ready_x                  : lane accepts a word this cycle.
//   o_data_x, o_status_x       : corrected data and status code.
//   o_err_pos_x                : flipped bit position, 0 = none.
//   o_valid_x, i_ready_x       : output handshake.
//   o_corr_cnt_x, o_uncorr_cnt_x : saturating error counters.
//   i_clr_cnt                  : synchronous clear of all four counters.
module ham_dec_pipe
  import ham_pkg::*;
#(
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int PARITY_BITS  = $clog2(DATA_BITS) + 1,
  parameter int ENCODED_WORD = DATA_BITS + PARITY_BITS,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [ENCODED_WORD+1:1]            i_data_a,
  input  logic                               i_valid_a,
  output logic                               o_ready_a,
  output logic [DATA_BITS-1:0]               o_data_a,
  output logic [1:0]                         o_status_a,
  output logic [$clog2(ENCODED_WORD+2)-1:0]  o_err_pos_a,
  output logic                               o_valid_a,
  input  logic                               i_ready_a,
  output logic [CNT_W-1:0]                   o_corr_cnt_a,
  output logic [CNT_W-1:0]                   o_uncorr_cnt_a,
  input  logic [ENCODED_WORD+1:1]            i_data_b,
  input  logic                               i_valid_b,
  output logic                               o_ready_b,
  output logic [DATA_BITS-1:0]               o_data_b,
  output logic [1:0]                         o_status_b,
  output logic [$clog2(ENCODED_WORD+2)-1:0]  o_err_pos_b,
  output logic                               o_valid_b,
  input  logic                               i_ready_b,
  output logic [CNT_W-1:0]                   o_corr_cnt_b,
  output logic [CNT_W-1:0]                   o_uncorr_cnt_b,
  input  logic                               i_clr_cnt
);

  ham_dec_pipe_if #(.DATA_BITS(DATA_BITS), .ENCODED_WORD(ENCODED_WORD), .CNT_W(CNT_W)) u_bus_a ();
  ham_dec_pipe_if #(.DATA_BITS(DATA_BITS), .ENCODED_WORD(ENCODED_WORD), .CNT_W(CNT_W)) u_bus_b ();

  assign u_bus_a.in_data   = i_data_a;
  assign u_bus_a.in_valid  = i_valid_a;
  assign u_bus_a.out_ready = i_ready_a;
  assign o_ready_a         = u_bus_a.in_ready;
  assign o_data_a          = u_bus_a.out_data;
  assign o_status_a        = u_bus_a.out_status;
  assign o_err_pos_a       = u_bus_a.out_err_pos;
  assign o_valid_a         = u_bus_a.out_valid;
  assign o_corr_cnt_a      = u_bus_a.corr_cnt;
  assign o_uncorr_cnt_a    = u_bus_a.uncorr_cnt;

  assign u_bus_b.in_data   = i_data_b;
  assign u_bus_b.in_valid  = i_valid_b;
  assign u_bus_b.out_ready = i_ready_b;
  assign o_ready_b         = u_bus_b.in_ready;
  assign o_data_b          = u_bus_b.out_data;
  assign o_status_b        = u_bus_b.out_status;
  assign o_err_pos_b       = u_bus_b.out_err_pos;
  assign o_valid_b         = u_bus_b.out_valid;
  assign o_corr_cnt_b      = u_bus_b.corr_cnt;
  assign o_uncorr_cnt_b    = u_bus_b.uncorr_cnt;

  ham_dec_lane #(
    .DATA_BITS(DATA_BITS), .PARITY_BITS(PARITY_BITS),
    .ENCODED_WORD(ENCODED_WORD), .CNT_W(CNT_W)
  ) u_lane_a (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr_cnt(i_clr_cnt), .bus(u_bus_a.slave)
  );

  ham_dec_lane #(
    .DATA_BITS(DATA_BITS), .PARITY_BITS(PARITY_BITS),
    .ENCODED_WORD(ENCODED_WORD), .CNT_W(CNT_W)
  ) u_lane_b (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr_cnt(i_clr_cnt), .bus(u_bus_b.slave)
  );

endmodule

// File: tb/tb_ham_dec_pipe.sv
// tb/tb_ham_dec_pipe.sv - directed self-checking bench for ham_dec_pipe
module tb_ham_dec_pipe;
  import ham_pkg::*;

  localparam int DB = 8;
  localparam int PB = 4;
  localparam int EW = 12;
  localparam int CW = 16;

  logic i_clk = 1'b0;
  logic i_rst;
  logic i_clr_cnt;
  int   n_cmp  = 0;
  int   n_fail = 0;

  ham_dec_pipe_if #(.DATA_BITS(DB), .ENCODED_WORD(EW), .CNT_W(CW)) u_if_a ();
  ham_dec_pipe_if #(.DATA_BITS(DB), .ENCODED_WORD(EW), .CNT_W(CW)) u_if_b ();

  ham_dec_pipe #(.DATA_BITS(DB), .PARITY_BITS(PB), .ENCODED_WORD(EW), .CNT_W(CW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_data_a(u_if_a.in_data), .i_valid_a(u_if_a.in_valid), .o_ready_a(u_if_a.in_ready),
    .o_data_a(u_if_a.out_data), .o_status_a(u_if_a.out_status), .o_err_pos_a(u_if_a.out_err_pos),
    .o_valid_a(u_if_a.out_valid), .i_ready_a(u_if_a.out_ready),
    .o_corr_cnt_a(u_if_a.corr_cnt), .o_uncorr_cnt_a(u_if_a.uncorr_cnt),
    .i_data_b(u_if_b.in_data), .i_valid_b(u_if_b.in_valid), .o_ready_b(u_if_b.in_ready),
    .o_data_b(u_if_b.out_data), .o_status_b(u_if_b.out_status), .o_err_pos_b(u_if_b.out_err_pos),
    .o_valid_b(u_if_b.out_valid), .i_ready_b(u_if_b.out_ready),
    .o_corr_cnt_b(u_if_b.corr_cnt), .o_uncorr_cnt_b(u_if_b.uncorr_cnt),
    .i_clr_cnt(i_clr_cnt)
  );

  always #5 i_clk = ~i_clk;

  // {valid, data, status, pos}
  logic [14:0] w_obs_a, w_obs_b;
  assign w_obs_a = {u_if_a.out_valid, u_if_a.out_data, u_if_a.out_status, u_if_a.out_err_pos};
  assign w_obs_b = {u_if_b.out_valid, u_if_b.out_data, u_if_b.out_status, u_if_b.out_err_pos};

  // Present one word at a negedge; returns two cycles later with the result on the outputs.
  task automatic pass_word(input bit lane_b, input logic [13:1] w);
    @(negedge i_clk);
    if (lane_b) begin u_if_b.in_data = w; u_if_b.in_valid = 1'b1; end
    else        begin u_if_a.in_data = w; u_if_a.in_valid = 1'b1; end
    @(negedge i_clk);
    u_if_a.in_valid = 1'b0;
    u_if_b.in_valid = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    u_if_a.in_data = '0; u_if_a.in_valid = 1'b0; u_if_a.out_ready = 1'b1;
    u_if_b.in_data = '0; u_if_b.in_valid = 1'b0; u_if_b.out_ready = 1'b1;
    i_clr_cnt = 1'b0;
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    n_cmp++;
    if (w_obs_a !== 15'h0) begin n_fail++; $display("FAIL reset_out_a got %h want 0000", w_obs_a); end
    n_cmp++;
    if (w_obs_b !== 15'h0) begin n_fail++; $display("FAIL reset_out_b got %h want 0000", w_obs_b); end
    n_cmp++;
    if ({u_if_a.corr_cnt, u_if_a.uncorr_cnt, u_if_b.corr_cnt, u_if_b.uncorr_cnt} !== 64'h0) begin
      n_fail++; $display("FAIL reset_cnt got %h %h %h %h want 0", u_if_a.corr_cnt, u_if_a.uncorr_cnt,
                         u_if_b.corr_cnt, u_if_b.uncorr_cnt);
    end
    i_rst = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if ({u_if_a.in_ready, u_if_b.in_ready} !== 2'b11) begin
      n_fail++; $display("FAIL reset_ready got %b%b want 11", u_if_a.in_ready, u_if_b.in_ready);
    end
  endtask

  task automatic test_clean();
    pass_word(1'b0, 13'h0A27);
    n_cmp++;
    if (w_obs_a !== {1'b1, 8'hA5, 2'b00, 4'd0}) begin n_fail++; $display("FAIL clean_out got %h want %h", w_obs_a, {1'b1, 8'hA5, 2'b00, 4'd0}); end
    @(negedge i_clk);
    n_cmp++;
    if ({u_if_a.out_valid, u_if_a.corr_cnt, u_if_a.uncorr_cnt} !== {1'b0, 16'd0, 16'd0}) begin
      n_fail++; $display("FAIL clean_cnt got v=%b c=%0d u=%0d want v=0 c=0 u=0", u_if_a.out_valid, u_if_a.corr_cnt, u_if_a.uncorr_cnt);
    end
  endtask

  task automatic test_corrected();
    logic [13:1] words [3] = '{13'h0A07, 13'h0A26, 13'h0227};
    logic [3:0]  pos   [3] = '{4'd6, 4'd1, 4'd12};
    for (int i = 0; i < 3; i++) begin
      pass_word(1'b0, words[i]);
      n_cmp++;
      if (w_obs_a !== {1'b1, 8'hA5, 2'b01, pos[i]}) begin
        n_fail++; $display("FAIL corrected_%0d got %h want %h", i, w_obs_a, {1'b1, 8'hA5, 2'b01, pos[i]});
      end
      @(negedge i_clk);
      n_cmp++;
      if (u_if_a.corr_cnt !== 16'(i + 1)) begin
        n_fail++; $display("FAIL corrected_cnt_%0d got %0d want %0d", i, u_if_a.corr_cnt, i + 1);
      end
    end
  endtask

  task automatic test_multi();
    pass_word(1'b0, 13'h0AAE);
    n_cmp++;
    if (w_obs_a !== {1'b1, 8'hA5, 2'b11, 4'd0}) begin n_fail++; $display("FAIL multi_out got %h want %h", w_obs_a, {1'b1, 8'hA5, 2'b11, 4'd0}); end
    @(negedge i_clk);
    n_cmp++;
    if ({u_if_a.corr_cnt, u_if_a.uncorr_cnt} !== {16'd3, 16'd1}) begin
      n_fail++; $display("FAIL multi_cnt got c=%0d u=%0d want c=3 u=1", u_if_a.corr_cnt, u_if_a.uncorr_cnt);
    end
  endtask

  task automatic test_lane_b();
    pass_word(1'b1, 13'h0807);
    n_cmp++;
    if (w_obs_b !== {1'b1, 8'h81, 2'b10, 4'd0}) begin n_fail++; $display("FAIL b_double_out got %h want %h", w_obs_b, {1'b1, 8'h81, 2'b10, 4'd0}); end
    n_cmp++;
    if (u_if_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL b_isolation_valid got %b want 0", u_if_a.out_valid); end
    @(negedge i_clk);
    n_cmp++;
    if ({u_if_b.corr_cnt, u_if_b.uncorr_cnt, u_if_a.corr_cnt, u_if_a.uncorr_cnt} !== {16'd0, 16'd1, 16'd3, 16'd1}) begin
      n_fail++; $display("FAIL b_double_cnt got b=%0d/%0d a=%0d/%0d want b=0/1 a=3/1",
                         u_if_b.corr_cnt, u_if_b.uncorr_cnt, u_if_a.corr_cnt, u_if_a.uncorr_cnt);
    end
    pass_word(1'b1, 13'h1A27);
    n_cmp++;
    if (w_obs_b !== {1'b1, 8'hA5, 2'b01, 4'd13}) begin n_fail++; $display("FAIL b_par13_out got %h want %h", w_obs_b, {1'b1, 8'hA5, 2'b01, 4'd13}); end
    @(negedge i_clk);
    n_cmp++;
    if (u_if_b.corr_cnt !== 16'd1) begin n_fail++; $display("FAIL b_par13_cnt got %0d want 1", u_if_b.corr_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [13:1] words [4] = '{13'h0A27, 13'h0A07, 13'h0807, 13'h1A27};
    logic [14:0] exp   [4] = '{{1'b1, 8'hA5, 2'b00, 4'd0}, {1'b1, 8'hA5, 2'b01, 4'd6},
                               {1'b1, 8'h81, 2'b10, 4'd0}, {1'b1, 8'hA5, 2'b01, 4'd13}};
    int tx = 0;
    int rx = 0;
    for (int c = 0; c < 40 && rx < 4; c++) begin
      @(negedge i_clk);
      u_if_a.out_ready = !(c >= 3 && c <= 5);
      if (tx < 4) begin u_if_a.in_data = words[tx]; u_if_a.in_valid = 1'b1; end
      else u_if_a.in_valid = 1'b0;
      #1;
      if (c >= 3 && c <= 5) begin
        n_cmp++;
        if (u_if_a.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_ready c=%0d got %b want 0", c, u_if_a.in_ready); end
        n_cmp++;
        if (w_obs_a !== exp[1]) begin n_fail++; $display("FAIL b2b_stall_hold c=%0d got %h want %h", c, w_obs_a, exp[1]); end
      end
      if (u_if_a.out_valid && u_if_a.out_ready) begin
        n_cmp++;
        if (w_obs_a !== exp[rx]) begin n_fail++; $display("FAIL b2b_word_%0d got %h want %h", rx, w_obs_a, exp[rx]); end
        rx++;
      end
      if (u_if_a.in_valid && u_if_a.in_ready) tx++;
    end
    u_if_a.in_valid  = 1'b0;
    u_if_a.out_ready = 1'b1;
    n_cmp++;
    if (rx !== 4) begin n_fail++; $display("FAIL b2b_count got %0d want 4", rx); end
    repeat (2) @(negedge i_clk);
    n_cmp++;
    if (u_if_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_no_dup got %b want 0", u_if_a.out_valid); end
    n_cmp++;
    if ({u_if_a.corr_cnt, u_if_a.uncorr_cnt} !== {16'd5, 16'd2}) begin
      n_fail++; $display("FAIL b2b_cnt got c=%0d u=%0d want c=5 u=2", u_if_a.corr_cnt, u_if_a.uncorr_cnt);
    end
  endtask

  task automatic test_saturation();
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    u_if_a.in_data  = 13'h0A07;
    u_if_a.in_valid = 1'b1;
    repeat (65535) @(negedge i_clk);
    u_if_a.in_valid = 1'b0;
    repeat (3) @(negedge i_clk);
    n_cmp++;
    if ({u_if_a.corr_cnt, u_if_a.uncorr_cnt} !== {16'hFFFF, 16'h0}) begin
      n_fail++; $display("FAIL sat_reach got c=%h u=%h want c=ffff u=0000", u_if_a.corr_cnt, u_if_a.uncorr_cnt);
    end
    pass_word(1'b0, 13'h0A07);
    pass_word(1'b0, 13'h0A26);
    @(negedge i_clk);
    n_cmp++;
    if (u_if_a.corr_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %h want ffff", u_if_a.corr_cnt); end
    pass_word(1'b1, 13'h0807);
    @(negedge i_clk);
    n_cmp++;
    if (u_if_b.uncorr_cnt !== 16'd1) begin n_fail++; $display("FAIL sat_b_uncorr got %0d want 1", u_if_b.uncorr_cnt); end
    pass_word(1'b0, 13'h0A07);
    i_clr_cnt = 1'b1;
    @(negedge i_clk);
    i_clr_cnt = 1'b0;
    n_cmp++;
    if ({u_if_a.corr_cnt, u_if_b.uncorr_cnt} !== 32'h0) begin
      n_fail++; $display("FAIL clr_sat got a=%h b=%h want 0", u_if_a.corr_cnt, u_if_b.uncorr_cnt);
    end
    pass_word(1'b0, 13'h0A07);
    i_clr_cnt = 1'b1;
    @(negedge i_clk);
    i_clr_cnt = 1'b0;
    n_cmp++;
    if (u_if_a.corr_cnt !== 16'd0) begin n_fail++; $display("FAIL clr_wins got %0d want 0", u_if_a.corr_cnt); end
  endtask

  task automatic test_reset_mid();
    pass_word(1'b0, 13'h0A07);
    @(negedge i_clk);
    n_cmp++;
    if (u_if_a.corr_cnt !== 16'd1) begin n_fail++; $display("FAIL mid_pre_cnt got %0d want 1", u_if_a.corr_cnt); end
    u_if_a.out_ready = 1'b0;
    u_if_a.in_data   = 13'h0A27;
    u_if_a.in_valid  = 1'b1;
    @(negedge i_clk);
    u_if_a.in_data   = 13'h0A07;
    @(negedge i_clk);
    u_if_a.in_valid  = 1'b0;
    n_cmp++;
    if ({w_obs_a, u_if_a.in_ready} !== {1'b1, 8'hA5, 2'b00, 4'd0, 1'b0}) begin
      n_fail++; $display("FAIL mid_full got %h rdy=%b want %h rdy=0", w_obs_a, u_if_a.in_ready, {1'b1, 8'hA5, 2'b00, 4'd0});
    end
    #2;
    i_rst = 1'b1;
    #1;
    n_cmp++;
    if ({w_obs_a, u_if_a.corr_cnt} !== 31'h0) begin
      n_fail++; $display("FAIL mid_async got %h cnt=%0d want 0000 cnt=0", w_obs_a, u_if_a.corr_cnt);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    u_if_a.out_ready = 1'b1;
    @(negedge i_clk);
    n_cmp++;
    if (u_if_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_discard got %b want 0", u_if_a.out_valid); end
    u_if_a.in_data  = 13'h1A27;
    u_if_a.in_valid = 1'b1;
    @(negedge i_clk);
    u_if_a.in_valid = 1'b0;
    n_cmp++;
    if (u_if_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_lat1 got %b want 0", u_if_a.out_valid); end
    @(negedge i_clk);
    n_cmp++;
    if (w_obs_a !== {1'b1, 8'hA5, 2'b01, 4'd13}) begin
      n_fail++; $display("FAIL mid_lat2 got %h want %h", w_obs_a, {1'b1, 8'hA5, 2'b01, 4'd13});
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_corrected();
    test_multi();
    test_lane_b();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
